// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Request/response channel between the memory stage and the
//               data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if #(
  parameter int ADDR_W = 64
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [ADDR_W-1:0] i_req_addr;
  logic [63:0]       i_req_wdata;
  logic [7:0]        i_req_be;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [63:0]       o_rsp_rdata;
  logic              o_rsp_err;

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_be, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_be, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-outstanding data-memory responder with configurable
//               wait states and byte-enabled doubleword access.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH    = 512,
  parameter int ADDR_W   = 64,
  parameter int WAIT_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_responder_if.slave     bus
);

  localparam int               c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               c_iw    = ADDR_W - 3;
  localparam logic [c_iw-1:0]  c_depth = c_iw'(DEPTH);
  localparam logic [3:0]       c_wait  = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic             r_we;
  logic [c_iw-1:0]  r_idx;
  logic [63:0]      r_wdata;
  logic [7:0]       r_be;
  logic             r_rsp_valid;
  logic [63:0]      r_rsp_rdata;
  logic             r_rsp_err;

  logic [63:0]      mem [DEPTH];

  logic             w_err;
  logic [c_aw-1:0]  w_idx;

  // Out-of-range indices are rejected rather than wrapped onto the array.
  assign w_err = (r_idx >= c_depth) || (r_be == 8'h00);
  assign w_idx = r_idx[c_aw-1:0];

  assign bus.o_req_ready = (r_state == S_IDLE);
  assign bus.o_rsp_valid = r_rsp_valid;
  assign bus.o_rsp_rdata = r_rsp_rdata;
  assign bus.o_rsp_err   = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_req_valid) begin
            r_we    <= bus.i_req_we;
            r_idx   <= bus.i_req_addr[ADDR_W-1:3];
            r_wdata <= bus.i_req_wdata;
            r_be    <= bus.i_req_be;
            r_cnt   <= c_wait;
            r_state <= (c_wait == 4'd0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= w_err;
          r_rsp_rdata <= (w_err || r_we) ? 64'd0 : mem[w_idx];
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Array is never reset; a reset during WAIT leaves r_state in IDLE so no write occurs.
  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS && r_we && !w_err) begin
      for (int b = 0; b < 8; b++) begin
        if (r_be[b]) begin
          mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH    = 512;
  localparam int ADDR_W   = 64;
  localparam int WAIT_CYC = 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  dmem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_responder #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .WAIT_CYC (WAIT_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full request/response exchange; latency counted in edges after the accept edge.
  task automatic txn(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                     input logic [7:0] be, input string tag,
                     output logic [63:0] rd, output logic er);
    int n;
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = we;
    bus.i_req_addr  = addr;
    bus.i_req_wdata = wd;
    bus.i_req_be    = be;
    n = 0;
    while (!bus.o_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, 64'(bus.o_req_ready), 64'd1);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    n = 1;
    while (!bus.o_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 64'(n - 1), 64'(WAIT_CYC + 1));
    rd = bus.o_rsp_rdata;
    er = bus.o_rsp_err;
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    bus.i_rsp_ready = 1'b0;
    chk({tag, "_drop"}, 64'(bus.o_rsp_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    int          n;
    bit          stray;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.i_req_valid = 1'b0;
    bus.i_req_we    = 1'b0;
    bus.i_req_addr  = '0;
    bus.i_req_wdata = '0;
    bus.i_req_be    = '0;
    bus.i_rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(bus.o_req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    chk("rst_rdata", bus.o_rsp_rdata, 64'd0);
    chk("rst_err", 64'(bus.o_rsp_err), 64'd0);
    rst_n = 1'b1;

    // Full store then load from an unaligned address in the same doubleword
    txn(1'b1, 64'h40, 64'h1122334455667788, 8'hFF, "st40", rd, er);
    chk("st40_rdata", rd, 64'd0);
    chk("st40_err", 64'(er), 64'd0);
    txn(1'b0, 64'h45, 64'd0, 8'h01, "ld45", rd, er);
    chk("ld45_rdata", rd, 64'h1122334455667788);
    chk("ld45_err", 64'(er), 64'd0);

    // Partial byte-enabled store
    txn(1'b1, 64'h40, 64'hAAAAAAAABBBBBBBB, 8'h0F, "st40p", rd, er);
    chk("st40p_err", 64'(er), 64'd0);
    txn(1'b0, 64'h40, 64'd0, 8'hFF, "ld40", rd, er);
    chk("ld40_rdata", rd, 64'h11223344BBBBBBBB);

    // Backpressure on the response with a second request waiting
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = 1'b0;
    bus.i_req_addr  = 64'h40;
    bus.i_req_be    = 8'hFF;
    @(negedge clk);
    chk("bp_accepted", 64'(bus.o_req_ready), 64'd0);
    bus.i_req_we    = 1'b1;
    bus.i_req_addr  = 64'h08;
    bus.i_req_wdata = 64'h0123456789ABCDEF;
    n = 0;
    while (!bus.o_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(bus.o_rsp_valid), 64'd1);
      chk("bp_rdata", bus.o_rsp_rdata, 64'h11223344BBBBBBBB);
      chk("bp_req_ready", 64'(bus.o_req_ready), 64'd0);
      @(negedge clk);
    end
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    bus.i_rsp_ready = 1'b0;
    chk("bp_hs_valid", 64'(bus.o_rsp_valid), 64'd0);
    chk("bp_hs_ready", 64'(bus.o_req_ready), 64'd1);
    @(negedge clk);
    chk("bp_second_acc", 64'(bus.o_req_ready), 64'd0);
    bus.i_req_valid = 1'b0;
    n = 1;
    while (!bus.o_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_second_lat", 64'(n - 1), 64'(WAIT_CYC + 1));
    chk("bp_second_err", 64'(bus.o_rsp_err), 64'd0);
    chk("bp_second_rdata", bus.o_rsp_rdata, 64'd0);
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    bus.i_rsp_ready = 1'b0;
    txn(1'b0, 64'h08, 64'd0, 8'h80, "ld08", rd, er);
    chk("ld08_rdata", rd, 64'h0123456789ABCDEF);

    // Out-of-range index and empty byte enable
    txn(1'b1, 64'h0, 64'hCAFEF00DDEADBEEF, 8'hFF, "st00", rd, er);
    txn(1'b1, 64'h1000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, "oob", rd, er);
    chk("oob_err", 64'(er), 64'd1);
    chk("oob_rdata", rd, 64'd0);
    txn(1'b0, 64'h0, 64'd0, 8'hFF, "ld00a", rd, er);
    chk("ld00a_rdata", rd, 64'hCAFEF00DDEADBEEF);
    txn(1'b1, 64'h0, 64'h0, 8'h00, "be0", rd, er);
    chk("be0_err", 64'(er), 64'd1);
    txn(1'b0, 64'h1008, 64'd0, 8'hFF, "ldoob", rd, er);
    chk("ldoob_err", 64'(er), 64'd1);
    chk("ldoob_rdata", rd, 64'd0);
    txn(1'b0, 64'h0, 64'd0, 8'hFF, "ld00b", rd, er);
    chk("ld00b_rdata", rd, 64'hCAFEF00DDEADBEEF);

    // Reset during WAIT drops the in-flight store
    txn(1'b1, 64'h80, 64'h0F0E0D0C0B0A0908, 8'hFF, "st80", rd, er);
    txn(1'b0, 64'h80, 64'd0, 8'hFF, "ld80a", rd, er);
    chk("ld80a_rdata", rd, 64'h0F0E0D0C0B0A0908);
    bus.i_rsp_ready = 1'b0;
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_req_we    = 1'b1;
    bus.i_req_addr  = 64'h80;
    bus.i_req_wdata = 64'hDEADDEADDEADDEAD;
    bus.i_req_be    = 8'hFF;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(bus.o_req_ready), 64'd1);
    chk("mid_rst_valid", 64'(bus.o_rsp_valid), 64'd0);
    chk("mid_rst_rdata", bus.o_rsp_rdata, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.o_rsp_valid) stray = 1'b1;
    end
    chk("no_stray_rsp", 64'(stray), 64'd0);
    txn(1'b0, 64'h80, 64'd0, 8'hFF, "ld80b", rd, er);
    chk("ld80b_rdata", rd, 64'h0F0E0D0C0B0A0908);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
